// File: rtl/wb_test_responder.sv
// wb_test_responder
//
// Wishbone classic-cycle responder used as a traffic sink for bring-up and
// regression benches. It holds a small flop-based register file, inserts
// pseudo-random wait states drawn from an 8-bit Galois LFSR, terminates
// out-of-window accesses with ERR, and counts ACK and ERR terminations.
//
// Handshake: a request is offered while s_CYC & s_STB are high and is
// accepted on the first edge the responder is idle. The master must hold
// the request until a termination (s_ACK or s_ERR, exactly one cycle) is
// seen. Dropping s_CYC or s_STB during wait states abandons the access:
// there is no write and no termination.
//
// Ports:
//   clk      clock
//   rstn     asynchronous active-low reset
//   s_ADR    byte address (s_ADR[1:0] ignored)
//   s_DAT_W  write data
//   s_SEL    byte enables
//   s_WE     write enable
//   s_CYC    cycle valid
//   s_STB    strobe
//   s_DAT_R  read data; zero unless a termination is being signalled
//   s_ACK    normal termination (in-window access)
//   s_ERR    error termination (out-of-window access), data 32'hDEAD_BEEF
//   acc_cnt  saturating count of ACK cycles
//   err_cnt  saturating count of ERR cycles
module wb_test_responder #(
    parameter int                       WB_ADDR_WIDTH = 32,
    parameter int                       WB_DATA_WIDTH = 32,
    parameter int                       MEM_ADDR_BITS = 4,
    parameter logic [WB_ADDR_WIDTH-1:0] ADDR_BASE     = '0,
    parameter int                       WAIT_EN       = 1,
    parameter logic [7:0]               LFSR_SEED     = 8'hA5
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [WB_ADDR_WIDTH-1:0]   s_ADR,
    input  logic [WB_DATA_WIDTH-1:0]   s_DAT_W,
    input  logic [WB_DATA_WIDTH/8-1:0] s_SEL,
    input  logic                       s_WE,
    input  logic                       s_CYC,
    input  logic                       s_STB,
    output logic [WB_DATA_WIDTH-1:0]   s_DAT_R,
    output logic                       s_ACK,
    output logic                       s_ERR,
    output logic [31:0]                acc_cnt,
    output logic [15:0]                err_cnt
);

    localparam int SW    = WB_DATA_WIDTH / 8;
    localparam int WORDS = 1 << MEM_ADDR_BITS;
    localparam logic [WB_ADDR_WIDTH-1:0] WIN_BYTES = WB_ADDR_WIDTH'(4 * WORDS);
    localparam logic [WB_DATA_WIDTH-1:0] ERR_DATA  = WB_DATA_WIDTH'(32'hDEAD_BEEF);
    // Galois right-shift tap mask for x^8+x^6+x^5+x^4+1.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [7:0]               lfsr_q;
    logic [7:0]               lfsr_next;
    logic [1:0]               wcnt_q;
    logic [1:0]               w_init;
    logic                     req;
    logic                     accept;

    logic [MEM_ADDR_BITS-1:0] idx_q;
    logic                     we_q;
    logic [SW-1:0]            sel_q;
    logic [WB_DATA_WIDTH-1:0] dat_q;
    logic                     hit_q;

    logic [WB_DATA_WIDTH-1:0] mem_q [WORDS];
    logic [31:0]              acc_q;
    logic [15:0]              err_q;

    // Extra top bit of the subtraction is the borrow: set when s_ADR lies
    // below the window base, which avoids a separate lower-bound compare.
    logic [WB_ADDR_WIDTH:0]   diff;
    logic                     hit_d;

    assign diff  = {1'b0, s_ADR} - {1'b0, ADDR_BASE};
    assign hit_d = !diff[WB_ADDR_WIDTH] && (diff[WB_ADDR_WIDTH-1:0] < WIN_BYTES);

    assign req       = s_CYC & s_STB;
    assign lfsr_next = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 8'h00);
    // Wait count comes from the LFSR value before it advances.
    assign w_init    = (WAIT_EN != 0) ? lfsr_q[1:0] : 2'd0;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    accept  = 1'b1;
                    state_d = (w_init == 2'd0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                // An abandoned request wins over the final wait cycle.
                if (!req) begin
                    state_d = ST_IDLE;
                end else if (wcnt_q == 2'd1) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, LFSR and request capture
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            lfsr_q  <= LFSR_SEED;
            wcnt_q  <= 2'd0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            dat_q   <= '0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                lfsr_q <= lfsr_next;
                wcnt_q <= w_init;
                idx_q  <= diff[MEM_ADDR_BITS+1:2];
                we_q   <= s_WE;
                sel_q  <= s_SEL;
                dat_q  <= s_DAT_W;
                hit_q  <= hit_d;
            end else if (state_q == ST_WAIT) begin
                wcnt_q <= wcnt_q - 2'd1;
            end
        end
    end

    // Register file: in-window writes commit at the end of the response cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (state_q == ST_RESP && hit_q && we_q) begin
            for (int b = 0; b < SW; b++) begin
                if (sel_q[b]) begin
                    mem_q[idx_q][8*b +: 8] <= dat_q[8*b +: 8];
                end
            end
        end
    end

    // Termination counters, saturating
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_q <= '0;
            err_q <= '0;
        end else if (state_q == ST_RESP) begin
            if (hit_q) begin
                if (acc_q != 32'hFFFF_FFFF) begin
                    acc_q <= acc_q + 32'd1;
                end
            end else begin
                if (err_q != 16'hFFFF) begin
                    err_q <= err_q + 16'd1;
                end
            end
        end
    end

    // Outputs are decoded from flops only; the asynchronous clear of
    // state_q drops them in the same cycle rstn falls.
    always_comb begin
        s_DAT_R = '0;
        if (state_q == ST_RESP) begin
            if (!hit_q) begin
                s_DAT_R = ERR_DATA;
            end else if (!we_q) begin
                s_DAT_R = mem_q[idx_q];
            end
        end
    end

    assign s_ACK   = (state_q == ST_RESP) &&  hit_q;
    assign s_ERR   = (state_q == ST_RESP) && !hit_q;
    assign acc_cnt = acc_q;
    assign err_cnt = err_q;

endmodule
